// File: rtl/vga_draw_pkg.sv
// Shared definitions for the sprite renderer: FSM encoding, screen size, palette.
package vga_draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ERASE = 3'd2,
    S_DRAW  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam int XSCREEN_DEF = 160;
  localparam int YSCREEN_DEF = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;

endpackage

// File: rtl/rect_scan.sv
// Raster counters for one XDIM x YDIM box: xc runs fastest, yc steps when xc wraps.
module rect_scan #(
  parameter int XDIM = 10,
  parameter int YDIM = 10
) (
  input  logic       CLOCK_50,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] xc,
  output logic [3:0] yc,
  output logic       last
);

  // Advance one pixel per enabled cycle; wraps to (0,0) after the last pixel.
  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      xc <= 4'd0;
      yc <= 4'd0;
    end else if (enable) begin
      if (xc == 4'(XDIM - 1)) begin
        xc <= 4'd0;
        yc <= (yc == 4'(YDIM - 1)) ? 4'd0 : yc + 4'd1;
      end else begin
        xc <= xc + 4'd1;
      end
    end
  end

  assign last = (xc == 4'(XDIM - 1)) && (yc == 4'(YDIM - 1));

endmodule

// File: rtl/sprite_draw_engine.sv
// Multi-object box renderer: per pass, erase every previously drawn box, then
// draw every enabled box, one pixel per cycle into the VGA adapter.
module sprite_draw_engine
  import vga_draw_pkg::*;
#(
  parameter int NOBJ    = 2,
  parameter int XDIM    = 10,
  parameter int YDIM    = 10,
  parameter int XSCREEN = XSCREEN_DEF,
  parameter int YSCREEN = YSCREEN_DEF
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic              start,
  input  logic [8*NOBJ-1:0] obj_x,
  input  logic [7*NOBJ-1:0] obj_y,
  input  logic [3*NOBJ-1:0] obj_colour,
  input  logic [NOBJ-1:0]   obj_en,
  input  logic [2:0]        bg_colour,
  output logic              busy,
  output logic              done,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              plot
);

  state_t            state;
  logic [2:0]        idx;
  logic [NOBJ-1:0]   old_valid;
  logic [NOBJ-1:0]   new_en;
  logic [8*NOBJ-1:0] new_x, old_x;
  logic [7*NOBJ-1:0] new_y, old_y;
  logic [3*NOBJ-1:0] new_colour;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] cur_colour;
  logic       cur_old_valid, cur_new_en;
  logic       active, idx_last, obj_end;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic [3:0] xc, yc;
  logic       scan_last;

  rect_scan #(.XDIM(XDIM), .YDIM(YDIM)) u_scan (
    .CLOCK_50 (CLOCK_50),
    .clear    (!Resetn || (state == S_LATCH)),
    .enable   (active),
    .xc       (xc),
    .yc       (yc),
    .last     (scan_last)
  );

  // Select the current object's box and drive the adapter for this cycle.
  always_comb begin
    base_x        = 8'd0;
    base_y        = 7'd0;
    cur_colour    = 3'd0;
    cur_old_valid = 1'b0;
    cur_new_en    = 1'b0;
    for (int k = 0; k < NOBJ; k++) begin
      if (idx == 3'(k)) begin
        cur_old_valid = old_valid[k];
        cur_new_en    = new_en[k];
        cur_colour    = (state == S_ERASE) ? bg_colour : new_colour[3*k +: 3];
        base_x        = (state == S_ERASE) ? old_x[8*k +: 8] : new_x[8*k +: 8];
        base_y        = (state == S_ERASE) ? old_y[7*k +: 7] : new_y[7*k +: 7];
      end
    end
    active   = ((state == S_ERASE) && cur_old_valid) || ((state == S_DRAW) && cur_new_en);
    idx_last = (idx == 3'(NOBJ - 1));
    obj_end  = !active || scan_last;
    // Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
    sum_x    = {1'b0, base_x} + {5'd0, xc};
    sum_y    = {1'b0, base_y} + {4'd0, yc};
    plot       = active && (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
    vga_x      = active ? sum_x[7:0] : 8'd0;
    vga_y      = active ? sum_y[6:0] : 7'd0;
    vga_colour = active ? cur_colour : 3'd0;
  end

  // Pass sequencer: latch, erase all old boxes, draw all new boxes, commit.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= 3'd0;
      old_valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_LATCH;
            busy  <= 1'b1;
          end
        end
        S_LATCH: begin
          idx   <= 3'd0;
          state <= S_ERASE;
        end
        S_ERASE: begin
          if (obj_end) begin
            if (idx_last) begin
              idx   <= 3'd0;
              state <= S_DRAW;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_DRAW: begin
          if (obj_end) begin
            if (idx_last) begin
              idx   <= 3'd0;
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_FIN: begin
          old_valid <= new_en;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Object shadows: snapshot inputs at LATCH, promote to "old" at FIN.
  always_ff @(posedge CLOCK_50) begin
    if (state == S_LATCH) begin
      new_x      <= obj_x;
      new_y      <= obj_y;
      new_colour <= obj_colour;
      new_en     <= obj_en;
    end
    if (state == S_FIN) begin
      old_x <= new_x;
      old_y <= new_y;
    end
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Bench for sprite_draw_engine: directed scenarios plus random passes against a
// pixel-list model of erase-then-draw rendering.
module tb_sprite_draw_engine;
  import vga_draw_pkg::*;

  localparam int NOBJ = 2;
  localparam int XD   = 2;
  localparam int YD   = 2;

  logic              CLOCK_50 = 1'b0;
  logic              Resetn;
  logic              start;
  logic [8*NOBJ-1:0] obj_x;
  logic [7*NOBJ-1:0] obj_y;
  logic [3*NOBJ-1:0] obj_colour;
  logic [NOBJ-1:0]   obj_en;
  logic [2:0]        bg_colour;
  logic              busy, done, plot;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;

  int total = 0;
  int bad   = 0;

  int m_ox[NOBJ];
  int m_oy[NOBJ];
  bit m_ov[NOBJ];

  always #10 CLOCK_50 = ~CLOCK_50;

  sprite_draw_engine #(.NOBJ(NOBJ), .XDIM(XD), .YDIM(YD)) dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .start      (start),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_colour (obj_colour),
    .obj_en     (obj_en),
    .bg_colour  (bg_colour),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int x, input int y, input int c);
    return x * 1024 + y * 8 + c;
  endfunction

  // Append the visible pixels of one box to q; returns cycles spent on it.
  function automatic int box(ref int q[$], input int bx, input int by, input int c);
    for (int yy = 0; yy < YD; yy++)
      for (int xx = 0; xx < XD; xx++)
        if (bx + xx < 160 && by + yy < 120) q.push_back(pix((bx + xx) % 256, (by + yy) % 128, c));
    return XD * YD;
  endfunction

  task automatic run_pass(input string tag, input int x0, input int y0, input int x1,
                          input int y1, input int c0, input int c1, input int en,
                          input int bg, input bit hold);
    int exp_q[$];
    int obs_q[$];
    int nx[NOBJ];
    int ny[NOBJ];
    int nc[NOBJ];
    int work = 0;
    int cyc, done_cyc, done_cnt, busy_cnt, n;
    nx[0] = x0; ny[0] = y0; nc[0] = c0;
    nx[1] = x1; ny[1] = y1; nc[1] = c1;
    for (int i = 0; i < NOBJ; i++)
      if (m_ov[i]) work += box(exp_q, m_ox[i], m_oy[i], bg); else work++;
    for (int i = 0; i < NOBJ; i++)
      if (en[i]) work += box(exp_q, nx[i], ny[i], nc[i]); else work++;

    @(negedge CLOCK_50);
    obj_x      = {8'(x1), 8'(x0)};
    obj_y      = {7'(y1), 7'(y0)};
    obj_colour = {3'(c1), 3'(c0)};
    obj_en     = 2'(en);
    bg_colour  = 3'(bg);
    start      = 1'b1;
    cyc = 1; done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    while (cyc < 200 && (done_cyc == 0 || cyc < done_cyc + 4)) begin
      @(negedge CLOCK_50);
      cyc++;
      if (cyc == 2 && !hold) start = 1'b0;
      if (cyc == 3) begin
        obj_x      = 16'($urandom);
        obj_y      = 14'($urandom);
        obj_colour = 6'($urandom);
        obj_en     = 2'($urandom);
      end
      if (busy) busy_cnt++;
      if (plot) obs_q.push_back(pix(vga_x, vga_y, vga_colour));
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cyc == 0) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_latency"}, done_cyc, 3 + work);
    chk({tag, "_busy_cycles"}, busy_cnt, work + 2);
    chk({tag, "_plot_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_pix%0d", tag, k), obs_q[k], exp_q[k]);
    for (int i = 0; i < NOBJ; i++) begin
      m_ox[i] = nx[i]; m_oy[i] = ny[i]; m_ov[i] = en[i];
    end
  endtask

  initial begin
    Resetn = 1'b0; start = 1'b0; obj_x = '0; obj_y = '0; obj_colour = '0;
    obj_en = '0; bg_colour = '0;
    for (int i = 0; i < NOBJ; i++) begin m_ox[i] = 0; m_oy[i] = 0; m_ov[i] = 0; end
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
    Resetn = 1'b1;
    @(negedge CLOCK_50);

    // First draw: nothing to erase yet.
    run_pass("first", 10, 20, 30, 40, RED, GREEN, 3, BLACK, 1'b0);
    // obj0 moves; erase both old boxes, draw both new.
    run_pass("move", 12, 20, 30, 40, RED, GREEN, 3, BLACK, 1'b0);
    // Bottom-right corner clipping.
    run_pass("clip", 159, 119, 30, 40, RED, GREEN, 3, 3'b001, 1'b0);
    // obj1 disabled: erased, not redrawn.
    run_pass("disable", 50, 60, 30, 40, GREEN, GREEN, 1, BLACK, 1'b0);
    run_pass("after_dis", 50, 61, 30, 40, RED, RED, 3, BLACK, 1'b0);
    // start held through the whole pass.
    run_pass("hold", 70, 80, 90, 100, RED, GREEN, 3, BLACK, 1'b1);

    // Reset in the middle of DRAW: both old boxes valid, 8 erase cycles first.
    @(negedge CLOCK_50);
    obj_x = {8'd5, 8'd6}; obj_y = {7'd7, 7'd8}; obj_en = 2'b11; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    Resetn = 1'b0;
    @(negedge CLOCK_50);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_done", int'(done), 0);
    Resetn = 1'b1;
    for (int i = 0; i < NOBJ; i++) m_ov[i] = 0;
    run_pass("post_rst", 20, 30, 40, 50, GREEN, RED, 3, BLACK, 1'b0);

    // Random passes, positions spanning past the screen edges.
    for (int t = 0; t < 12; t++)
      run_pass($sformatf("rnd%0d", t), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(140, 255)), int'($urandom_range(100, 127)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
